// File: rtl/muldiv_if.sv
// Execute-stage request and HI/LO result bundle for the
// iterative multiply/divide unit.
interface muldiv_if #(
  parameter int WIDTH = 32
);
  logic             start_i;
  logic             flush_i;
  logic [1:0]       op_i;
  logic             signed_i;
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic             hilo_rd_i;
  logic             busy_o;
  logic             stall_o;
  logic             done_o;
  logic [WIDTH-1:0] hi_o;
  logic [WIDTH-1:0] lo_o;

  modport master (
    output start_i, flush_i, op_i, signed_i,
    output a_i, b_i, hilo_rd_i,
    input  busy_o, stall_o, done_o, hi_o, lo_o
  );

  modport slave (
    input  start_i, flush_i, op_i, signed_i,
    input  a_i, b_i, hilo_rd_i,
    output busy_o, stall_o, done_o, hi_o, lo_o
  );
endinterface

// File: rtl/muldiv_seq.sv
// Bit-serial mul/div sequencer owning HI/LO.
// Define MULDIV_SIGNED_EN to build MULT/DIV sign handling.
module muldiv_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input logic     clk,
  input logic     rst_n,
  muldiv_if.slave bus
);
  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [1:0] OP_MUL  = 2'b00;
  localparam logic [1:0] OP_DIV  = 2'b01;
  localparam logic [1:0] OP_MTHI = 2'b10;
  localparam logic [1:0] OP_MTLO = 2'b11;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mq_q, mq_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             div_q, div_d;
  logic             done_q, done_d;

  logic             accept;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH-1:0] res_hi, res_lo;
  logic [WIDTH:0]   mul_sum, div_sh, div_df;
  logic [WIDTH-1:0] it_acc, it_mq;

  assign accept = (state_q == IDLE) & bus.start_i
                & ~bus.flush_i;

`ifdef MULDIV_SIGNED_EN
  logic neg_q, neg_d, rneg_q, rneg_d, sa, sb;

  assign sa    = bus.signed_i & bus.a_i[WIDTH-1];
  assign sb    = bus.signed_i & bus.b_i[WIDTH-1];
  assign a_mag = sa ? -bus.a_i : bus.a_i;
  assign b_mag = sb ? -bus.b_i : bus.b_i;

  always_comb begin
    neg_d  = neg_q;
    rneg_d = rneg_q;
    if (accept) begin
      neg_d  = sa ^ sb;
      rneg_d = sa;
    end
  end

  // Product and quotient follow sign XOR; remainder follows dividend.
  always_comb begin
    res_hi = it_acc;
    res_lo = it_mq;
    if (div_q) begin
      res_lo = neg_q  ? -it_mq  : it_mq;
      res_hi = rneg_q ? -it_acc : it_acc;
    end else if (neg_q) begin
      {res_hi, res_lo} = -{it_acc, it_mq};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      neg_q  <= 1'b0;
      rneg_q <= 1'b0;
    end else begin
      neg_q  <= neg_d;
      rneg_q <= rneg_d;
    end
  end
`else
  logic unused_sign;

  assign unused_sign = bus.signed_i;
  assign a_mag       = bus.a_i;
  assign b_mag       = bus.b_i;
  assign res_hi      = it_acc;
  assign res_lo      = it_mq;
`endif

  // acc is the running high product / partial remainder.
  always_comb begin
    mul_sum = {1'b0, acc_q}
            + (mq_q[0] ? {1'b0, opb_q} : '0);
    div_sh  = {acc_q, mq_q[WIDTH-1]};
    div_df  = div_sh - {1'b0, opb_q};
    if (div_q) begin
      it_acc = div_df[WIDTH] ? div_sh[WIDTH-1:0]
                             : div_df[WIDTH-1:0];
      it_mq  = {mq_q[WIDTH-2:0], ~div_df[WIDTH]};
    end else begin
      it_acc = mul_sum[WIDTH:1];
      it_mq  = {mul_sum[0], mq_q[WIDTH-1:1]};
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    mq_d    = mq_q;
    opb_d   = opb_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    div_d   = div_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          unique case (bus.op_i)
            OP_MTHI: hi_d = bus.a_i;
            OP_MTLO: lo_d = bus.a_i;
            OP_MUL, OP_DIV: begin
              state_d = BUSY;
              cnt_d   = CNT_W'(WIDTH - 1);
              acc_d   = '0;
              div_d   = (bus.op_i == OP_DIV);
              mq_d    = div_d ? a_mag : b_mag;
              opb_d   = div_d ? b_mag : a_mag;
            end
            default: ;
          endcase
        end
      end
      BUSY: begin
        acc_d = it_acc;
        mq_d  = it_mq;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          state_d = IDLE;
          cnt_d   = '0;
          hi_d    = res_hi;
          lo_d    = res_lo;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      mq_q    <= '0;
      opb_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      div_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      mq_q    <= mq_d;
      opb_q   <= opb_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      div_q   <= div_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy_o  = (state_q == BUSY);
  assign bus.stall_o = bus.busy_o
                     & (bus.start_i | bus.hilo_rd_i);
  assign bus.done_o  = done_q;
  assign bus.hi_o    = hi_q;
  assign bus.lo_o    = lo_q;
endmodule
